neuron_update_sched: RTL and testbench
======================================

# neuron_update_sched

Time-step scheduler and synaptic accumulator that sits directly upstream of `neuron_core`. Incoming weighted spike events are accepted over a valid/ready handshake and summed per target neuron with saturation. On each time-step tick the block sweeps all N neurons in address order. For each neuron it issues one `CTRL_NEUR_EVENT` pulse carrying the neuron address and its accumulated synaptic current, then clears that accumulator.

## Interface
Parameters:
- `N`, 256, neurons per core (power of two, ≥ 4)
- `ADDR_W`, 8, address width, $clog2(N)
- `DATA_W`, 16, signed current width
- `VIRT_I`, 0, constant signed value driven on `virtual_current`

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; the block resets while `reset` = 0
- `tick`  in  1  time-step strobe, sampled only in IDLE
- `in_valid`  in  1  synaptic event valid
- `in_ready`  out  1  synaptic event accepted when `in_valid` && `in_ready`
- `in_addr`  in  ADDR_W  target neuron
- `in_weight`  in  DATA_W signed  synaptic weight
- `neuron_ready`  in  1  downstream can take an update; the sweep stalls while low
- `CTRL_NEUR_EVENT`  out  1  one-cycle update pulse to `neuron_core`
- `neuron_addr`  out  ADDR_W  neuron being updated
- `syn_current`  out  DATA_W signed  accumulated current for `neuron_addr`
- `virtual_current`  out  DATA_W signed  constant `VIRT_I`
- `busy`  out  1  sweep in progress (state ≠ IDLE)
- `step_done`  out  1  one-cycle pulse at end of sweep
- `overrun`  out  1  sticky; a tick arrived while not IDLE

## Operation
- Storage: `acc[0:N-1]`, signed DATA_W, all zero at reset.
- **IDLE**
  - `in_ready` = 1.
  - On each handshake, `acc[in_addr]` is set to sat(`acc[in_addr]` + `in_weight`).
  - Saturation bounds are +2^(DATA_W-1)-1 and -2^(DATA_W-1).
  - `tick` = 1 → SWEEP with `ptr` = 0.
  - If a handshake and `tick` occur in the same cycle, the event is accumulated and is included in this sweep.
- **SWEEP**
  - `in_ready` = 0.
  - At each edge where `neuron_ready` = 1:
    - register `CTRL_NEUR_EVENT` = 1, `neuron_addr` = `ptr`, `syn_current` = `acc[ptr]`;
    - set `acc[ptr]` = 0;
    - `ptr` = `ptr` + 1.
  - At an edge where `neuron_ready` = 0, `CTRL_NEUR_EVENT` is 0 and `ptr` holds.
  - The edge that issues `ptr` = N-1 → DONE. `ptr` never wraps.
- **DONE**
  - Registers `step_done` = 1 for one cycle.
  - → IDLE.
- `tick` while in SWEEP or DONE:
  - ignored; no queued step;
  - `overrun` is set and stays set until reset.
- `neuron_addr` and `syn_current` hold their last values when `CTRL_NEUR_EVENT` = 0.
- Reset (asynchronous):
  - state IDLE; `ptr`, every `acc`, and all outputs are 0, except `in_ready` = 1;
  - `virtual_current` = `VIRT_I`.
- Reset mid-sweep: the step is abandoned, the pulse drops immediately, and all accumulators are cleared.

## Timing
All cycle numbers below are relative to the edge `k` at which `tick` is sampled in IDLE.

- Edge k: state becomes SWEEP.
- Edge k+1: first pulse (addr 0) is registered.
- Without stalls: pulses for addr i are registered at edges k+1…k+N.
- Edge k+N: state becomes DONE.
- `step_done` is high for exactly one cycle, after edge k+N+1.
- Edge k+N+1: state returns to IDLE; `in_ready` is high from then on.
- Minimum tick-to-tick period: N+2 cycles.
- Each `neuron_ready` = 0 edge adds one cycle to every later timing in this list.
- Accumulate path: single cycle. A same-address back-to-back event on the next cycle sees the updated value; the read-modify-write completes within one cycle.

## Configuration
- `NEUR_SCHED_OVERRUN_CNT_EN`
  - Defined: adds output `overrun_cnt` [7:0]. It increments on each ignored tick, saturates at 255, and resets to 0.
  - Undefined: the port and counter are absent; only the sticky `overrun` flag exists.

## Structure
- Shared package `neur_pkg` holds:
  - `sched_state_t` enum {IDLE, SWEEP, DONE};
  - localparams `SYN_MAX` and `SYN_MIN` derived from DATA_W;
  - function `sat_add`.
- One sub-module, `syn_sat_acc`: combinational DATA_W saturating adder used on the accumulate path.
- The accumulator array is inferred memory with one read/write port per path. A sweep read and an accumulate are never concurrent, because they are state-exclusive.

## Test plan
1. **Basic accumulation and sweep (N = 4).** Events (2, +3), (2, +4), (0, -5), then tick.
   Required: pulses addr 0..3 with `syn_current` = -5, 0, 7, 0; `step_done` one cycle after addr 3; all acc zero afterwards (a second tick gives all zeros).
2. **Saturation.** Send (1, +30000) twice, DATA_W = 16, then tick.
   Required: addr 1 carries 32767. Repeat with negatives and expect -32768.
3. **Backpressure and stall.** Drive `in_valid` during a sweep, and hold `neuron_ready` = 0 for 3 cycles mid-sweep.
   Required: `in_ready` = 0 throughout SWEEP/DONE; no event is lost once IDLE returns; no pulses while stalled; addresses stay contiguous; `step_done` is delayed by 3 cycles.
4. **Simultaneous event and tick.** Accept (3, +9) in the same cycle as tick.
   Required: addr 3 carries 9.
5. **Tick during sweep.** Tick at k+2.
   Required: sweep unaffected; `overrun` = 1 and stays 1; no second sweep; `overrun_cnt` = 1 when `NEUR_SCHED_OVERRUN_CNT_EN` is defined.
6. **Reset mid-sweep.** Assert `reset` = 0 at k+2.
   Required: `CTRL_NEUR_EVENT` drops immediately; `busy` = 0; `in_ready` = 1; a following tick sweeps all zeros.

Source files
------------

// File: rtl/neur_pkg.sv
`timescale 1ns/1ps
// neur_pkg: shared scheduler state type, synaptic saturation bounds and saturating add helper.
package neur_pkg;

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} sched_state_t;

   localparam int SYN_DATA_W = 16;
   localparam logic signed [SYN_DATA_W-1:0] SYN_MAX = {1'b0, {(SYN_DATA_W-1){1'b1}}};
   localparam logic signed [SYN_DATA_W-1:0] SYN_MIN = {1'b1, {(SYN_DATA_W-1){1'b0}}};

   // Adds two sign-extended operands and clamps the sum to the range of a w-bit signed value.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int w);
      logic signed [32:0] s, hi, lo;
      s  = 33'(a) + 33'(b);
      hi = (33'sd1 <<< (w - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (w - 1));
      return (s > hi) ? hi[31:0] : (s < lo) ? lo[31:0] : s[31:0];
   endfunction

endpackage

// File: rtl/syn_sat_acc.sv
`timescale 1ns/1ps
// syn_sat_acc: combinational DATA_W-bit signed saturating adder for the synaptic accumulate path.
module syn_sat_acc
   import neur_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic signed [DATA_W-1:0] a_i,
   input  logic signed [DATA_W-1:0] b_i,
   output logic signed [DATA_W-1:0] sum_o
);

   assign sum_o = DATA_W'(sat_add(32'(a_i), 32'(b_i), DATA_W));

endmodule

// File: rtl/neuron_update_sched.sv
`timescale 1ns/1ps
// neuron_update_sched: per-neuron saturating synaptic accumulator plus a time-step sweep feeding neuron_core.
// Optional feature: define NEUR_SCHED_OVERRUN_CNT_EN to add the saturating 8-bit overrun_cnt output.
module neuron_update_sched
   import neur_pkg::*;
#(
   parameter int N = 256,
   parameter int ADDR_W = $clog2(N),
   parameter int DATA_W = 16,
   parameter logic signed [DATA_W-1:0] VIRT_I = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     tick,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic signed [DATA_W-1:0] in_weight,
   input  logic                     neuron_ready,
   output logic                     CTRL_NEUR_EVENT,
   output logic [ADDR_W-1:0]        neuron_addr,
   output logic signed [DATA_W-1:0] syn_current,
   output logic signed [DATA_W-1:0] virtual_current,
   output logic                     busy,
   output logic                     step_done,
   output logic                     overrun
`ifdef NEUR_SCHED_OVERRUN_CNT_EN
   ,
   output logic [7:0]               overrun_cnt
`endif
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

   sched_state_t state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q;
   logic signed [DATA_W-1:0] acc [N];
   logic signed [DATA_W-1:0] acc_sum, cur_q;
   logic accept, fire, tick_lost, ev_q, done_q, overrun_q;

   assign accept          = in_valid && in_ready;
   assign CTRL_NEUR_EVENT = ev_q;
   assign neuron_addr     = addr_q;
   assign syn_current     = cur_q;
   assign virtual_current = VIRT_I;
   assign busy            = state_q != IDLE;
   assign step_done       = done_q;
   assign overrun         = overrun_q;

   syn_sat_acc #(.DATA_W(DATA_W)) u_sat_acc (
      .a_i  (acc[in_addr]),
      .b_i  (in_weight),
      .sum_o(acc_sum)
   );

   // Sweep control: IDLE takes events and ticks, SWEEP walks ptr while downstream is ready, DONE closes the step.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      fire      = 1'b0;
      in_ready  = state_q == IDLE;
      tick_lost = tick && (state_q != IDLE);
      case (state_q)
         IDLE: if (tick) begin
            state_d = SWEEP;
            ptr_d   = '0;
         end
         SWEEP: if (neuron_ready) begin
            fire    = 1'b1;
            state_d = (ptr_q == LAST) ? DONE : SWEEP;
            ptr_d   = (ptr_q == LAST) ? ptr_q : ptr_q + ADDR_W'(1);
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and sweep pointer registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_acc
      logic signed [DATA_W-1:0] entry_q;
      assign acc[i] = entry_q;
      // Accumulate the handshake target while idle; clear the entry as the sweep reads it out.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) entry_q <= '0;
         else if (accept && in_addr == ADDR_W'(i)) entry_q <= acc_sum;
         else if (fire && ptr_q == ADDR_W'(i)) entry_q <= '0;
      end
   end

   // Registered update pulse with held address/current, end-of-step pulse and sticky overrun flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ev_q      <= 1'b0;
         addr_q    <= '0;
         cur_q     <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         ev_q      <= fire;
         done_q    <= state_q == DONE;
         overrun_q <= overrun_q | tick_lost;
         if (fire) begin
            addr_q <= ptr_q;
            cur_q  <= acc[ptr_q];
         end
      end
   end

`ifdef NEUR_SCHED_OVERRUN_CNT_EN
   logic [7:0] ocnt_q;
   assign overrun_cnt = ocnt_q;

   // Count ignored ticks, saturating at 255.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ocnt_q <= '0;
      else if (tick_lost && ocnt_q != 8'hFF) ocnt_q <= ocnt_q + 8'd1;
   end
`endif

endmodule

// File: tb/tb_neuron_update_sched.sv
`timescale 1ns/1ps
// tb_neuron_update_sched: randomized and directed stimulus with a scoreboard of expected update pulses.
module tb_neuron_update_sched;

   localparam int N  = 4;
   localparam int AW = 2;
   localparam int DW = 16;
   localparam int VI = 123;

   logic clk = 1'b0, reset = 1'b0, tick = 1'b0, in_valid = 1'b0, neuron_ready = 1'b1;
   logic in_ready, ctrl_neur_event, busy, step_done, overrun;
   logic [AW-1:0] in_addr = '0;
   logic [AW-1:0] neuron_addr;
   logic signed [DW-1:0] in_weight = '0;
   logic signed [DW-1:0] syn_current, virtual_current;
`ifdef NEUR_SCHED_OVERRUN_CNT_EN
   logic [7:0] overrun_cnt;
`endif

   neuron_update_sched #(.N(N), .ADDR_W(AW), .DATA_W(DW), .VIRT_I(16'sd123)) dut (
      .clk            (clk),
      .reset          (reset),
      .tick           (tick),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_addr        (in_addr),
      .in_weight      (in_weight),
      .neuron_ready   (neuron_ready),
      .CTRL_NEUR_EVENT(ctrl_neur_event),
      .neuron_addr    (neuron_addr),
      .syn_current    (syn_current),
      .virtual_current(virtual_current),
      .busy           (busy),
      .step_done      (step_done),
      .overrun        (overrun)
`ifdef NEUR_SCHED_OVERRUN_CNT_EN
      ,
      .overrun_cnt    (overrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {int e; int a; int c;} pulse_t;

   int vectors = 0, miscompares = 0;
   pulse_t pq[$];
   int dq[$];
   bit pat[$];
   int acc_m[N];
   int edge_n = 0, idle_from = 0, ov_m = 0, oc_m = 0, last_a = 0, last_c = 0;

   function automatic void chk(string nm, longint got, longint exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_n, got, exp);
      end
   endfunction

   function automatic int sat(int x);
      return (x > 32767) ? 32767 : (x < -32768) ? -32768 : x;
   endfunction

   function automatic int rw();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                         : int'($urandom_range(0, 200)) - 100;
   endfunction

   function automatic void clear_model();
      pq.delete();
      dq.delete();
      foreach (acc_m[i]) acc_m[i] = 0;
      idle_from = 0;
      ov_m = 0;
      oc_m = 0;
      last_a = 0;
      last_c = 0;
   endfunction

   // A tick at edge e snapshots every accumulator into the pulse schedule, honouring the stall pattern.
   function automatic void schedule(int e);
      int ed = e + 1, i = 0, jp = 0;
      while (i < N) begin
         bit r = (jp < pat.size()) ? pat[jp] : 1'b1;
         jp++;
         if (r) begin
            pq.push_back('{ed, i, acc_m[i]});
            acc_m[i] = 0;
            i++;
         end
         ed++;
      end
      dq.push_back(ed);
      idle_from = ed + 1;
   endfunction

   task automatic cyc(bit v, int a, int w, bit t, bit r);
      in_valid = v;
      in_addr = AW'(a);
      in_weight = DW'(w);
      tick = t;
      neuron_ready = r;
      @(posedge clk);
      edge_n++;
      if (reset) begin
         if (edge_n >= idle_from) begin
            if (v) acc_m[a] = sat(acc_m[a] + w);
            if (t) schedule(edge_n);
         end else if (t) begin
            ov_m = 1;
            if (oc_m < 255) oc_m++;
         end
      end
      #1;
   endtask

   task automatic reset_mid();
      reset = 1'b0;
      #1;
      chk("rst_pulse", ctrl_neur_event, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      clear_model();
      cyc(0, 0, 0, 0, 1);
      reset = 1'b1;
   endtask

   task automatic sweep(bit tv, int ta, int tw, bit sv, int sa, int sw, int xt, int ra);
      int j = 0;
      cyc(tv, ta, tw, 1, 1);
      while (edge_n + 1 < idle_from) begin
         bit r;
         j++;
         r = (pat.size() != 0) ? pat.pop_front() : 1'b1;
         cyc(sv, sa, sw, j == xt, r);
         if (j == ra) reset_mid();
      end
      pat.delete();
      cyc(sv, sa, sw, 0, 1);
      cyc(0, 0, 0, 0, 1);
   endtask

   // Monitor: pops expected pulses / step_done edges and checks the per-cycle status outputs.
   always @(negedge clk) begin : mon
      pulse_t p;
      if (reset) begin
         if (ctrl_neur_event) begin
            if (pq.size() == 0) chk("spurious_pulse", ctrl_neur_event, 0);
            else begin
               p = pq[0];
               pq.delete(0);
               chk("pulse_edge", edge_n, p.e);
               chk("pulse_addr", neuron_addr, p.a);
               chk("pulse_cur", $signed(syn_current), p.c);
               last_a = p.a;
               last_c = p.c;
            end
         end else begin
            while (pq.size() != 0 && pq[0].e <= edge_n) begin
               chk("missing_pulse", ctrl_neur_event, 1);
               pq.delete(0);
            end
            chk("hold_addr", neuron_addr, last_a);
            chk("hold_cur", $signed(syn_current), last_c);
         end
         if (step_done) begin
            if (dq.size() == 0) chk("spurious_done", step_done, 0);
            else begin
               chk("done_edge", edge_n, dq[0]);
               dq.delete(0);
            end
         end else
            while (dq.size() != 0 && dq[0] <= edge_n) begin
               chk("missing_done", step_done, 1);
               dq.delete(0);
            end
         chk("busy", busy, edge_n < idle_from - 1);
         chk("in_ready", in_ready, edge_n >= idle_from - 1);
         chk("overrun", overrun, ov_m);
`ifdef NEUR_SCHED_OVERRUN_CNT_EN
         chk("overrun_cnt", overrun_cnt, oc_m);
`endif
         chk("virtual_current", $signed(virtual_current), VI);
      end
   end

   initial begin
      clear_model();
      repeat (2) cyc(0, 0, 0, 0, 1);
      chk("reset_pulse", ctrl_neur_event, 0);
      chk("reset_addr", neuron_addr, 0);
      chk("reset_cur", $signed(syn_current), 0);
      chk("reset_busy", busy, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_done", step_done, 0);
      chk("reset_overrun", overrun, 0);
      chk("reset_virtual", $signed(virtual_current), VI);
      reset = 1'b1;
      cyc(0, 0, 0, 0, 1);
      // basic accumulation: expect -5, 0, 7, 0 then an all-zero sweep
      cyc(1, 2, 3, 0, 1);
      cyc(1, 2, 4, 0, 1);
      cyc(1, 0, -5, 0, 1);
      sweep(0, 0, 0, 0, 0, 0, -1, -1);
      sweep(0, 0, 0, 0, 0, 0, -1, -1);
      // saturation both ways
      cyc(1, 1, 30000, 0, 1);
      cyc(1, 1, 30000, 0, 1);
      sweep(0, 0, 0, 0, 0, 0, -1, -1);
      cyc(1, 1, -30000, 0, 1);
      cyc(1, 1, -30000, 0, 1);
      sweep(0, 0, 0, 0, 0, 0, -1, -1);
      // backpressure during sweep with a three-cycle downstream stall; held event lands once idle
      pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      sweep(0, 0, 0, 1, 2, 11, -1, -1);
      sweep(0, 0, 0, 0, 0, 0, -1, -1);
      // event accepted in the tick cycle joins this sweep
      sweep(1, 3, 9, 0, 0, 0, -1, -1);
      // tick during the sweep is ignored and flagged
      sweep(0, 0, 0, 0, 0, 0, 2, -1);
      cyc(0, 0, 0, 0, 1);
      // reset mid-sweep abandons the step and clears accumulators
      cyc(1, 1, 77, 0, 1);
      cyc(1, 3, -8, 0, 1);
      sweep(0, 0, 0, 0, 0, 0, -1, 2);
      cyc(1, 2, 5, 0, 1);
      reset_mid();
      sweep(0, 0, 0, 0, 0, 0, -1, -1);
      // randomized traffic, stalls, overruns and occasional mid-sweep reset
      for (int it = 0; it < 30; it++) begin
         int ne = $urandom_range(0, 6);
         for (int k = 0; k < ne; k++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, N - 1), rw(), 0, $urandom_range(0, 1) != 0);
         for (int k = 0; k < 8; k++) pat.push_back($urandom_range(0, 2) != 0);
         sweep($urandom_range(0, 1) != 0, $urandom_range(0, N - 1), rw(),
               $urandom_range(0, 1) != 0, $urandom_range(0, N - 1), rw(),
               $urandom_range(0, 10), (it % 10 == 7) ? int'($urandom_range(1, 4)) : -1);
      end
      repeat (4) cyc(0, 0, 0, 0, 1);
      chk("pending_pulses", pq.size(), 0);
      chk("pending_done", dq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
